mips_debug_dumper: RTL and testbench
====================================

Name: mips_debug_dumper

Overview:
- Reports MIPS state to the host PC after the processor halts.
- Snapshots the PC and the cycle counter, reads all 32 general-purpose registers through a spare register-file read port, and serializes everything into a byte stream for the UART transmitter.
- Sits between top_mips and the uart_tx byte interface.

Parameters:
- LEN, 32, datapath word width in bits (multiple of 8).
- NB_REG_ADDR, 5, register-file address width.
- N_REGS, 32, number of registers dumped.
- HEADER, 8'hA5, frame start byte.

Ports:
- clk  input  1  system clock, all logic on rising edge
- reset  input  1  synchronous, active-high reset
- i_halt  input  1  level from the MIPS, high while the core is halted
- i_pc  input  LEN  current program counter
- i_cycles  input  LEN  executed-cycle counter
- o_reg_addr  output  NB_REG_ADDR  register-file debug read address
- i_reg_data  input  LEN  register-file debug read data, valid 1 cycle after o_reg_addr (registered read)
- o_tx_data  output  8  byte to transmit
- o_tx_valid  output  1  o_tx_data is valid
- i_tx_ready  input  1  transmitter accepts a byte; a transfer happens on an edge where o_tx_valid and i_tx_ready are both high
- o_busy  output  1  dump in progress
- o_dump_done  output  1  one-cycle pulse after the last byte is accepted

Behaviour:
- Reset values: o_tx_data=0, o_tx_valid=0, o_reg_addr=0, o_busy=0, o_dump_done=0; FSM in IDLE; halt edge detector cleared (prev=0).
- Frame is sent in this order; each word is sent MSB byte first:
  - HEADER (1 byte)
  - PC (4 bytes)
  - cycles (4 bytes)
  - R0..R(N_REGS-1) (4 bytes each)
  - Total 9+4*N_REGS bytes, which is 137 at the defaults.
- Trigger:
  - A rising edge of i_halt is sampled at edge k (prev=0, now=1) while in IDLE.
  - At that edge the block latches i_pc and i_cycles.
  - After edge k: o_busy=1, o_tx_valid=1, o_tx_data=HEADER.
- FSM states:
  - IDLE: wait for trigger.
  - SEND: present the current byte and hold it until accepted.
  - FETCH: drive o_reg_addr = register index; 1 cycle.
  - LOAD: capture i_reg_data into the 32-bit shift register; 1 cycle.
  - DONE: pulse o_dump_done, then go to IDLE.
- Transitions:
  - After the HEADER and PC/cycles bytes are accepted, the next byte is presented on the following cycle with no gap.
  - After the last byte of the cycles word or of any register word is accepted:
    - if registers remain, SEND -> FETCH -> LOAD -> SEND;
    - otherwise SEND -> DONE.
  - o_tx_valid is low during FETCH and LOAD. The maximum gap between words is 2 cycles.
- Handshake rules:
  - While o_tx_valid=1 and i_tx_ready=0, o_tx_data and o_tx_valid are held stable.
  - o_tx_valid never drops without a transfer, except on reset.
  - i_tx_ready may be high while o_tx_valid=0; this has no effect.
- Counters:
  - Byte index is 2 bits and wraps 3 -> 0 on each word.
  - Word counter runs 0..N_REGS+1 (0=PC, 1=cycles, n+2=Rn).
  - o_reg_addr = word counter - 2, truncated to NB_REG_ADDR bits.
  - o_reg_addr holds its last value outside FETCH.
- Boundary conditions:
  - i_halt toggling or staying high during a dump is ignored.
  - A new dump requires i_halt to be low for at least one sampled cycle after DONE and then rise again.
  - i_pc and i_cycles changes after the trigger do not affect the frame.
  - i_reg_data is sampled only in LOAD.
  - Reset mid-frame: all outputs go to their reset values at that edge and the partial frame is abandoned. If i_halt is still high after reset, no dump starts until i_halt falls and rises again.
- o_dump_done is high for exactly 1 cycle, in the cycle after the final transfer; o_busy falls in the same cycle.

Optional Feature:
- Macro: DUMP_CHECKSUM_EN.
- When defined:
  - After R(N_REGS-1), one extra byte is sent: the XOR of all payload bytes (the header is excluded).
  - The XOR accumulator clears at trigger and updates on every accepted payload byte.
  - Frame length is 138 at the defaults; o_dump_done follows acceptance of the checksum byte.
- When undefined: no accumulator is built and the frame is 137 bytes.

Test Plan:
- Basic dump, i_tx_ready tied to 1:
  - Setup: i_pc=32'h0000_0040, i_cycles=32'd123 (0x7B), register file Rn=n*32'h01010101; raise i_halt.
  - Required: exactly 137 transfers. Bytes 0..8 = A5 00 00 00 40 00 00 00 7B. Bytes 9..12 = 00 00 00 00 (R0). Last 4 bytes = 1F 1F 1F 1F. o_dump_done pulses once.
- Backpressure: same setup, i_tx_ready pseudo-random at about 30% duty -> o_tx_data stable whenever valid && !ready; received stream identical to the basic-dump stream.
- Snapshot and retrigger:
  - Change i_pc to 32'hDEAD_BEEF and pulse i_halt low/high mid-dump -> frame still carries PC 00000040; no second frame starts.
  - After done, drop i_halt for 1 cycle then raise it -> a second 137-byte frame is sent.
- Reset mid-frame: assert reset after byte 50 is accepted -> next cycle o_tx_valid=0, o_busy=0; holding i_halt high produces no new frame until i_halt falls and rises again.
- Register read timing: o_reg_addr steps 0..31, one value per word; the model returns data exactly 1 cycle late -> register bytes match; a bench check fails if the read data is sampled a cycle early.
- DUMP_CHECKSUM_EN: basic-dump setup -> byte 137 equals the XOR of bytes 1..136; frame length 138.

Source files
------------

// File: rtl/mips_debug_dumper.sv
// mips_debug_dumper: after a halt edge, streams HEADER, PC, cycles and R0..R(N_REGS-1) (MSB byte first) to a UART byte interface.
// Optional macro DUMP_CHECKSUM_EN appends one XOR checksum byte over the payload.
module mips_debug_dumper #(
  parameter int         LEN         = 32,
  parameter int         NB_REG_ADDR = 5,
  parameter int         N_REGS      = 32,
  parameter logic [7:0] HEADER      = 8'hA5
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   i_halt,
  input  logic [LEN-1:0]         i_pc,
  input  logic [LEN-1:0]         i_cycles,
  output logic [NB_REG_ADDR-1:0] o_reg_addr,
  input  logic [LEN-1:0]         i_reg_data,
  output logic [7:0]             o_tx_data,
  output logic                   o_tx_valid,
  input  logic                   i_tx_ready,
  output logic                   o_busy,
  output logic                   o_dump_done
);
  localparam int NB = LEN / 8;
  localparam int BW = NB > 1 ? $clog2(NB) : 1;
  localparam int WW = $clog2(N_REGS + 3);
  typedef enum logic [2:0] {IDLE, SEND, FETCH, LOAD, DONE} state_t;
  state_t         state_q;
  logic           halt_q, arm_q, hdr_q;
  logic [BW-1:0]  byte_q;
  logic [WW-1:0]  word_q;
  logic [LEN-1:0] sh_q, cyc_q, nxt_sh;
  logic           xfer, last_byte, trig;
  assign xfer      = o_tx_valid && i_tx_ready;
  assign last_byte = byte_q == BW'(NB - 1);
  assign nxt_sh    = sh_q << 8;
  // arm_q blocks a trigger until i_halt has been seen low since reset
  assign trig      = i_halt && !halt_q && arm_q;
`ifdef DUMP_CHECKSUM_EN
  logic [7:0] csum_q;
  always_ff @(posedge clk)
    if (reset || state_q == IDLE) csum_q <= '0;
    else if (xfer && !hdr_q) csum_q <= csum_q ^ o_tx_data;
`endif
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      halt_q      <= 1'b0;
      arm_q       <= 1'b0;
      hdr_q       <= 1'b0;
      byte_q      <= '0;
      word_q      <= '0;
      sh_q        <= '0;
      cyc_q       <= '0;
      o_tx_data   <= '0;
      o_tx_valid  <= 1'b0;
      o_reg_addr  <= '0;
      o_busy      <= 1'b0;
      o_dump_done <= 1'b0;
    end else begin
      halt_q <= i_halt;
      arm_q  <= arm_q | ~i_halt;
      case (state_q)
        IDLE: if (trig) begin
          sh_q       <= i_pc;
          cyc_q      <= i_cycles;
          hdr_q      <= 1'b1;
          byte_q     <= '0;
          word_q     <= '0;
          o_tx_data  <= HEADER;
          o_tx_valid <= 1'b1;
          o_busy     <= 1'b1;
          state_q    <= SEND;
        end
        SEND: if (xfer) begin
          hdr_q <= 1'b0;
          if (hdr_q) o_tx_data <= sh_q[LEN-1 -: 8];
          else if (!last_byte) begin
            sh_q      <= nxt_sh;
            o_tx_data <= nxt_sh[LEN-1 -: 8];
            byte_q    <= byte_q + BW'(1);
          end else begin
            byte_q <= '0;
            if (word_q == '0) begin
              word_q    <= WW'(1);
              sh_q      <= cyc_q;
              o_tx_data <= cyc_q[LEN-1 -: 8];
            end else if (word_q < WW'(N_REGS + 1)) begin
              word_q     <= word_q + WW'(1);
              o_reg_addr <= NB_REG_ADDR'(word_q - WW'(1));
              o_tx_valid <= 1'b0;
              state_q    <= FETCH;
            end
`ifdef DUMP_CHECKSUM_EN
            // checksum rides as a one-byte word; byte_q=last makes its acceptance finish the frame
            else if (word_q == WW'(N_REGS + 1)) begin
              word_q    <= word_q + WW'(1);
              byte_q    <= BW'(NB - 1);
              o_tx_data <= csum_q ^ o_tx_data;
            end
`endif
            else begin
              o_tx_valid  <= 1'b0;
              o_busy      <= 1'b0;
              o_dump_done <= 1'b1;
              state_q     <= DONE;
            end
          end
        end
        FETCH: state_q <= LOAD;
        LOAD: begin
          sh_q       <= i_reg_data;
          o_tx_data  <= i_reg_data[LEN-1 -: 8];
          o_tx_valid <= 1'b1;
          state_q    <= SEND;
        end
        DONE: begin
          o_dump_done <= 1'b0;
          state_q     <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mips_debug_dumper.sv
// tb_mips_debug_dumper: random-backpressure frame checks against a byte-list reference model with a registered-read register file.
module tb_mips_debug_dumper;
  logic        clk = 1'b0, reset = 1'b1, i_halt = 1'b0, i_tx_ready = 1'b0;
  logic [31:0] i_pc = '0, i_cycles = '0, i_reg_data;
  logic [4:0]  o_reg_addr;
  logic [7:0]  o_tx_data;
  logic        o_tx_valid, o_busy, o_dump_done;
  logic [31:0] regs [32];
  logic [7:0]  rx[$], exp_q[$];
  int          n_cmp = 0, n_bad = 0, duty = 100, done_cnt = 0, d0 = 0;
  logic        stall_q = 1'b0, rst_prev = 1'b1;
  logic [7:0]  held = '0;
  always #5 clk = ~clk;
  mips_debug_dumper dut (
    .clk(clk), .reset(reset), .i_halt(i_halt), .i_pc(i_pc), .i_cycles(i_cycles),
    .o_reg_addr(o_reg_addr), .i_reg_data(i_reg_data), .o_tx_data(o_tx_data),
    .o_tx_valid(o_tx_valid), .i_tx_ready(i_tx_ready), .o_busy(o_busy), .o_dump_done(o_dump_done)
  );
  // register file with a registered read port: data appears one cycle after the address
  always @(posedge clk) i_reg_data <= regs[o_reg_addr];
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  function automatic void push_word(input logic [31:0] w);
    for (int b = 3; b >= 0; b--) exp_q.push_back(w[8*b +: 8]);
  endfunction
  function automatic void build(input logic [31:0] pc, input logic [31:0] cyc);
    logic [7:0] x;
    x = '0;
    exp_q.delete();
    exp_q.push_back(8'hA5);
    push_word(pc);
    push_word(cyc);
    for (int r = 0; r < 32; r++) push_word(regs[r]);
`ifdef DUMP_CHECKSUM_EN
    for (int i = 1; i < exp_q.size(); i++) x ^= exp_q[i];
    exp_q.push_back(x);
`endif
  endfunction
  // receiver: picks ready at each negedge, logs transfers, checks hold-while-stalled
  initial forever begin
    logic rdy;
    @(negedge clk);
    rdy = $urandom_range(99) < duty;
    if (stall_q && !reset && !rst_prev) begin
      check("hold_valid", o_tx_valid, 1);
      check("hold_data", o_tx_data, held);
    end
    i_tx_ready = rdy;
    stall_q = o_tx_valid && !rdy;
    held = o_tx_data;
    if (o_tx_valid && rdy && !reset) rx.push_back(o_tx_data);
    if (o_dump_done) begin
      done_cnt++;
      check("busy_at_done", o_busy, 0);
    end
    rst_prev = reset;
  end
  task automatic start(input logic [31:0] pc, input logic [31:0] cyc);
    build(pc, cyc);
    i_halt = 1'b0;
    step();
    rx.delete();
    d0 = done_cnt;
    i_pc = pc;
    i_cycles = cyc;
    i_halt = 1'b1;
    step();
    check("trig_busy", o_busy, 1);
    check("trig_valid", o_tx_valid, 1);
    check("trig_hdr", o_tx_data, 8'hA5);
  endtask
  task automatic finish(input string tag);
    for (int i = 0; i < 6000 && done_cnt == d0; i++) step();
    repeat (3) step();
    check({tag, "_done_pulses"}, done_cnt - d0, 1);
    check({tag, "_len"}, rx.size(), exp_q.size());
    check({tag, "_last_addr"}, o_reg_addr, 31);
    for (int i = 0; i < exp_q.size(); i++)
      check($sformatf("%s_byte%0d", tag, i), i < rx.size() ? 64'(rx[i]) : 64'h100, exp_q[i]);
  endtask
  task automatic rand_regs();
    for (int r = 0; r < 32; r++) regs[r] = $urandom;
  endtask
  initial begin
    for (int r = 0; r < 32; r++) regs[r] = r * 32'h01010101;
    repeat (3) step();
    check("rst_valid", o_tx_valid, 0);
    check("rst_busy", o_busy, 0);
    check("rst_done", o_dump_done, 0);
    check("rst_data", o_tx_data, 0);
    check("rst_addr", o_reg_addr, 0);
    reset = 1'b0;
    duty = 100;
    start(32'h0000_0040, 32'd123);
    finish("basic");
    duty = 30;
    start(32'h0000_0040, 32'd123);
    for (int i = 0; i < 4000 && rx.size() < 40; i++) step();
    i_pc = 32'hDEAD_BEEF;
    i_cycles = 32'h1234_5678;
    i_halt = 1'b0;
    step();
    i_halt = 1'b1;
    step();
    finish("bp_snap");
    rx.delete();
    d0 = done_cnt;
    repeat (200) step();
    check("no_retrig_rx", rx.size(), 0);
    check("no_retrig_done", done_cnt - d0, 0);
    check("no_retrig_busy", o_busy, 0);
    rand_regs();
    start(32'hDEAD_BEEF, $urandom);
    finish("retrig");
    for (int k = 0; k < 3; k++) begin
      rand_regs();
      duty = $urandom_range(20, 100);
      start($urandom, $urandom);
      finish("rand");
    end
    duty = 60;
    rand_regs();
    start($urandom, $urandom);
    for (int i = 0; i < 4000 && rx.size() < 51; i++) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("mid_rst_valid", o_tx_valid, 0);
    check("mid_rst_busy", o_busy, 0);
    check("mid_rst_done", o_dump_done, 0);
    check("mid_rst_data", o_tx_data, 0);
    check("mid_rst_addr", o_reg_addr, 0);
    rx.delete();
    d0 = done_cnt;
    repeat (200) step();
    check("rst_hold_rx", rx.size(), 0);
    check("rst_hold_done", done_cnt - d0, 0);
    rand_regs();
    start($urandom, $urandom);
    finish("after_rst");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
